// File: rtl/serial_full_sub.sv
// serial_full_sub: bit-serial subtractor computing a - b - bin, LSB first.
// A single full-subtractor cell and a borrow flip-flop process one bit per
// clock. A start/busy/done handshake frames each WIDTH-cycle operation, and
// the result registers hold their value until the next operation completes.
//
// Build option: define SERIAL_FULL_SUB_OVF_EN to generate the signed
// overflow flag. Without it, ovf is tied to 0 and no sign-tracking logic
// exists. The port list is the same in both builds.
module serial_full_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   // The counter only has to reach WIDTH-1, the index of the last bit.
   localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Control decoded from the current state.
   logic load;
   logic step;
   logic last;

   // Operand shift registers, borrow flop, partial result and bit counter.
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sr;
   logic             br;
   logic [CNT_W-1:0] cnt;

   // Outputs of the full-subtractor cell for the current bit.
   logic             d_bit;
   logic             br_nxt;
   logic [WIDTH-1:0] sr_nxt;

   // Full-subtractor difference: x - y - bi, one bit.
   function automatic logic fs_diff(input logic x, input logic y, input logic bi);
      return x ^ y ^ bi;
   endfunction

   // Full-subtractor borrow: a borrow is needed when y exceeds x, or when
   // x equals y and a borrow is already pending.
   function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
      return (~x & y) | (~(x ^ y) & bi);
   endfunction

   assign d_bit  = fs_diff(sa[0], sb[0], br);
   assign br_nxt = fs_borrow(sa[0], sb[0], br);
   // The new bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
   assign sr_nxt = {d_bit, sr[WIDTH-1:1]};

   // State register; reset discards any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      last      = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt == CNT_LAST) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Serial datapath: capture operands on start, then one bit per RUN cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sa  <= '0;
         sb  <= '0;
         sr  <= '0;
         br  <= 1'b0;
         cnt <= '0;
      end else if (load) begin
         sa  <= a;
         sb  <= b;
         sr  <= '0;
         br  <= bin;
         cnt <= '0;
      end else if (step) begin
         sa  <= sa >> 1;
         sb  <= sb >> 1;
         sr  <= sr_nxt;
         br  <= br_nxt;
         cnt <= cnt + CNT_ONE;
      end
   end

   // Result registers load only while the last bit is processed, so partial
   // results are never visible on diff/bout.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         diff <= '0;
         bout <= 1'b0;
      end else if (last) begin
         diff <= sr_nxt;
         bout <= br_nxt;
      end
   end

`ifdef SERIAL_FULL_SUB_OVF_EN
   // Operand sign bits, kept for the overflow check at the end of the run.
   logic a_msb;
   logic b_msb;

   // Capture the operand signs on the accepted start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
      end else if (load) begin
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
      end
   end

   // Signed overflow: operands of different sign and a result whose sign
   // differs from the minuend. d_bit is the result MSB on the last step.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (last) begin
         ovf <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
      end
   end
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_full_sub.sv
// Testbench for serial_full_sub (WIDTH=8). A cycle-level model computes the
// expected outputs from plain integer arithmetic. A per-cycle compare process
// checks the DUT against it, and directed vectors with literal results pin
// the model itself.
module tb_serial_full_sub;

   localparam int W = 8;
`ifdef SERIAL_FULL_SUB_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         bin   = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_en  = 1'b0;

   serial_full_sub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Returns {ovf, bout, diff} for x - y - bi from integer arithmetic.
   function automatic logic [W+1:0] model_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic bi);
      int           ur;
      int           sres;
      logic         ov;
      logic [W-1:0] d;
      ur   = int'(x) - int'(y) - int'(bi);
      sres = int'($signed(x)) - int'($signed(y)) - int'(bi);
      ov   = OVF_ON && ((sres < -(2 ** (W - 1))) || (sres > (2 ** (W - 1)) - 1));
      d    = ur[W-1:0];
      return {ov, (ur < 0), d};
   endfunction

   // Timeline model: m_left counts the busy cycles remaining after an
   // accepted start (WIDTH run cycles plus the done cycle).
   int             m_left = 0;
   logic [W+1:0]   m_res  = '0;
   logic [W+1:0]   m_out  = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_left <= 0;
         m_out  <= '0;
      end else if (m_left == 0) begin
         if (start) begin
            m_left <= W + 1;
            m_res  <= model_sub(a, b, bin);
         end
      end else begin
         m_left <= m_left - 1;
         if (m_left == 2) m_out <= m_res;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_busy", busy, (m_left != 0));
         check("cyc_done", done, (m_left == 1));
         check("cyc_diff", diff, m_out[W-1:0]);
         check("cyc_bout", bout, m_out[W]);
         check("cyc_ovf",  ovf,  m_out[W+1]);
      end
   end

   // One operation with literal expectations; optionally drives extra start
   // pulses with other operands while the operation is running.
   task automatic run_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ibin, input logic [W-1:0] ed, input logic eb,
                         input logic eo, input bit noise);
      int e0;
      int guard;
      @(posedge clk); #2;
      a = ia; b = ib; bin = ibin; start = 1'b1;
      @(posedge clk); #2;
      e0 = cyc;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      if (noise) begin
         repeat (2) @(posedge clk);
         #2;
         a = 8'hF0; b = 8'h0F; bin = 1'b0; start = 1'b1;
         repeat (3) @(posedge clk);
         #2;
         start = 1'b0;
      end
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!done && guard < 40);
      if (!done) begin
         check({name, "_timeout"}, 1'b0, 1'b1);
      end else begin
         check({name, "_latency"}, 64'(cyc - e0), 64'(W));
         check({name, "_diff"}, diff, ed);
         check({name, "_bout"}, bout, eb);
         check({name, "_ovf"},  ovf,  eo);
      end
      @(negedge clk);
      check({name, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      int seen;
      // Reset held for two edges with start high.
      rst_n = 1'b0; start = 1'b1; a = 8'h55; b = 8'h22;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_diff", diff, 8'h00);
      check("rst_bout", bout, 1'b0);
      check("rst_ovf",  ovf,  1'b0);
      chk_en = 1'b1;
      @(posedge clk); #2;
      rst_n = 1'b1; start = 1'b0;

      run_op("basic",     8'h25, 8'h13, 1'b0, 8'h12, 1'b0, 1'b0,   1'b0);
      run_op("underflow", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0,   1'b0);
      run_op("sovf",      8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, OVF_ON, 1'b0);
      run_op("sovf_bin",  8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, OVF_ON, 1'b0);
      run_op("sovf_pos",  8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, OVF_ON, 1'b0);
      run_op("bin_noise", 8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0,   1'b1);

      // Reset in the middle of a run: no done, outputs cleared.
      @(posedge clk); #2;
      a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      seen = 0;
      repeat (14) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("midrst_no_done", 64'(seen), 64'd0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_diff", diff, 8'h00);
      check("midrst_bout", bout, 1'b0);
      check("midrst_ovf",  ovf,  1'b0);

      run_op("after_rst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
